// File: rtl/mmu_acc_drain_if.sv
// Beat stream from the accumulator drain toward requantization/writeback.
// master drives beats, slave applies backpressure through out_ready.
interface mmu_acc_drain_if #(
    parameter int acc_width = 24,
    parameter int mmu_block = 16,
    parameter int idx_w     = 3
);
    logic                          out_valid;
    logic                          out_ready;
    logic [acc_width*mmu_block-1:0] out_data;
    logic [idx_w-1:0]              out_idx;
    logic                          out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/mmu_acc_drain.sv
// Snapshots the chain accumulator vector on capture and streams it out in size/mmu_block beats.
// Optional MMU_ACC_DRAIN_RELU_EN zeroes negative lanes on the output mux path.
module mmu_acc_drain #(
    parameter int bit_width = 8,
    parameter int acc_width = 24,
    parameter int size      = 128,
    parameter int mmu_block = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      capture,
    input  logic [acc_width*size-1:0] acc_in,
    mmu_acc_drain_if.master           out_if,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun
);
    localparam int s_len = size / mmu_block;
    localparam int idx_w = (s_len > 1) ? $clog2(s_len) : 1;
    localparam int blk_w = acc_width * mmu_block;
    localparam logic [idx_w-1:0] last_idx = idx_w'(s_len - 1);

    if ((size % mmu_block) != 0 || bit_width < 1) begin : g_param_check
        $error("mmu_acc_drain: size must be a multiple of mmu_block");
    end

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e                    state_q, state_d;
    logic [acc_width*size-1:0] shadow_q, shadow_d;
    logic [idx_w-1:0]          idx_q, idx_d;
    logic                      done_q, done_d;
    logic                      overrun_q, overrun_d;
    logic                      sending;
    logic                      hs;
    logic                      at_last;
    logic [blk_w-1:0]          blk;

    assign sending = (state_q == SEND);
    assign hs      = sending && out_if.out_ready;
    assign at_last = (idx_q == last_idx);

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    shadow_d = acc_in;
                    idx_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (hs && at_last) begin
                    // Final handshake frees the shadow, so a coincident capture reloads with no bubble.
                    done_d = 1'b1;
                    idx_d  = '0;
                    if (capture) begin
                        shadow_d = acc_in;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (hs) begin
                        idx_d = idx_q + 1'b1;
                    end
                    if (capture) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        blk = shadow_q[idx_q*blk_w +: blk_w];
`ifdef MMU_ACC_DRAIN_RELU_EN
        for (int unsigned l = 0; l < mmu_block; l++) begin
            if (blk[l*acc_width + acc_width - 1]) begin
                blk[l*acc_width +: acc_width] = '0;
            end
        end
`endif
    end

    assign out_if.out_valid = sending;
    assign out_if.out_data  = sending ? blk : '0;
    assign out_if.out_idx   = idx_q;
    assign out_if.out_last  = sending && at_last;
    assign busy             = sending;
    assign done             = done_q;
    assign overrun          = overrun_q;
endmodule

// File: tb/tb_mmu_acc_drain.sv
// Self-checking bench for mmu_acc_drain: scenario tasks compare DUT beats against a lane-array model.
module tb_mmu_acc_drain;
    localparam int ACC  = 24;
    localparam int SIZE = 128;
    localparam int BLK  = 16;
    localparam int SLEN = SIZE / BLK;
    localparam int IDXW = 3;
    localparam int BW   = ACC * BLK;
    localparam int OW   = 5 + IDXW + BW;

    logic                clk = 1'b0;
    logic                rst;
    logic                capture;
    logic [ACC*SIZE-1:0] acc_in;
    logic                busy, done, overrun;

    int n_cmp = 0;
    int n_err = 0;

    int stim[SIZE];
    int ref_lanes[SIZE];

    mmu_acc_drain_if #(.acc_width(ACC), .mmu_block(BLK), .idx_w(IDXW)) bus ();

    mmu_acc_drain #(
        .bit_width(8),
        .acc_width(ACC),
        .size(SIZE),
        .mmu_block(BLK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .capture(capture),
        .acc_in(acc_in),
        .out_if(bus),
        .busy(busy),
        .done(done),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ACC*SIZE-1:0] pack_stim();
        logic [ACC*SIZE-1:0] p;
        logic [31:0] t;
        p = '0;
        for (int i = 0; i < SIZE; i++) begin
            t = stim[i];
            p[i*ACC +: ACC] = t[ACC-1:0];
        end
        return p;
    endfunction

    // Model beat k: lanes k*BLK .. k*BLK+BLK-1 of the accepted snapshot.
    function automatic logic [BW-1:0] exp_beat(int k);
        logic [BW-1:0] b;
        logic [31:0] t;
        int v;
        b = '0;
        for (int l = 0; l < BLK; l++) begin
            v = ref_lanes[k*BLK + l];
`ifdef MMU_ACC_DRAIN_RELU_EN
            if (v < 0) v = 0;
`endif
            t = v;
            b[l*ACC +: ACC] = t[ACC-1:0];
        end
        return b;
    endfunction

    function automatic logic [OW-1:0] obs();
        return {bus.out_valid, bus.out_last, busy, done, overrun, bus.out_idx, bus.out_data};
    endfunction

    function automatic logic [OW-1:0] beat_exp(int k, logic dn, logic ov);
        logic [IDXW-1:0] ki;
        ki = k[IDXW-1:0];
        return {1'b1, (k == SLEN - 1), 1'b1, dn, ov, ki, exp_beat(k)};
    endfunction

    function automatic logic [3:0] idle_obs();
        return {bus.out_valid, busy, done, overrun};
    endfunction

    task automatic fill_random;
        for (int i = 0; i < SIZE; i++) stim[i] = int'($urandom) >>> 8;
    endtask

    task automatic start_capture;
        capture = 1'b1;
        acc_in  = pack_stim();
        tick();
        capture = 1'b0;
        ref_lanes = stim;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        capture = 1'b0;
        acc_in = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (obs() !== '0) begin
            n_err++;
            $display("FAIL reset_hold: got %h want 0", obs());
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (obs() !== '0) begin
            n_err++;
            $display("FAIL reset_release: got %h want 0", obs());
        end
    endtask

    task automatic test_stream;
        for (int i = 0; i < SIZE; i++) stim[i] = i;
        bus.out_ready = 1'b1;
        start_capture();
        for (int k = 0; k < SLEN; k++) begin
            n_cmp++;
            if (obs() !== beat_exp(k, 1'b0, 1'b0)) begin
                n_err++;
                $display("FAIL stream_beat%0d: got %h want %h", k, obs(), beat_exp(k, 1'b0, 1'b0));
            end
            tick();
        end
        n_cmp++;
        if (idle_obs() !== 4'b0010) begin
            n_err++;
            $display("FAIL stream_done: got %b want 0010", idle_obs());
        end
        tick();
        n_cmp++;
        if (idle_obs() !== 4'b0000) begin
            n_err++;
            $display("FAIL stream_done_pulse: got %b want 0000", idle_obs());
        end
    endtask

    // rnd=0: ready pattern 1,0,0,1,...; rnd=1: random vectors and random ready.
    task automatic test_backpressure(input bit rnd, input int iters);
        int k, c;
        for (int it = 0; it < iters; it++) begin
            if (rnd) fill_random();
            else for (int i = 0; i < SIZE; i++) stim[i] = i;
            start_capture();
            k = 0;
            c = 0;
            while (k < SLEN && c < 200) begin
                bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : ((c % 3) == 0);
                n_cmp++;
                if (obs() !== beat_exp(k, 1'b0, 1'b0)) begin
                    n_err++;
                    $display("FAIL bp_beat%0d_cyc%0d: got %h want %h", k, c, obs(), beat_exp(k, 1'b0, 1'b0));
                end
                if (bus.out_ready) k++;
                tick();
                c++;
            end
            bus.out_ready = 1'b1;
            n_cmp++;
            if (c >= 200) begin
                n_err++;
                $display("FAIL bp_timeout: got %0d beats want %0d", k, SLEN);
            end
            n_cmp++;
            if (idle_obs() !== 4'b0010) begin
                n_err++;
                $display("FAIL bp_done: got %b want 0010", idle_obs());
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < SIZE; i++) stim[i] = i;
        bus.out_ready = 1'b1;
        start_capture();
        for (int k = 0; k < SLEN; k++) begin
            n_cmp++;
            if (obs() !== beat_exp(k, 1'b0, 1'b0)) begin
                n_err++;
                $display("FAIL b2b_a_beat%0d: got %h want %h", k, obs(), beat_exp(k, 1'b0, 1'b0));
            end
            if (k == SLEN - 1) begin
                for (int i = 0; i < SIZE; i++) stim[i] = 1000 + i;
                capture = 1'b1;
                acc_in = pack_stim();
            end
            tick();
        end
        capture = 1'b0;
        ref_lanes = stim;
        for (int k = 0; k < SLEN; k++) begin
            n_cmp++;
            if (obs() !== beat_exp(k, k == 0, 1'b0)) begin
                n_err++;
                $display("FAIL b2b_b_beat%0d: got %h want %h", k, obs(), beat_exp(k, k == 0, 1'b0));
            end
            tick();
        end
        n_cmp++;
        if (idle_obs() !== 4'b0010) begin
            n_err++;
            $display("FAIL b2b_done: got %b want 0010", idle_obs());
        end
        tick();
    endtask

    task automatic test_relu;
        logic [ACC-1:0] l0_exp;
`ifdef MMU_ACC_DRAIN_RELU_EN
        l0_exp = 24'h000000;
`else
        l0_exp = 24'hFFFFFB;
`endif
        for (int i = 0; i < SIZE; i++) stim[i] = (i % 2 == 0) ? -5 : 5;
        bus.out_ready = 1'b1;
        start_capture();
        n_cmp++;
        if (bus.out_data[2*ACC-1:0] !== {24'd5, l0_exp}) begin
            n_err++;
            $display("FAIL relu_lanes01: got %h want %h", bus.out_data[2*ACC-1:0], {24'd5, l0_exp});
        end
        for (int k = 0; k < SLEN; k++) begin
            n_cmp++;
            if (obs() !== beat_exp(k, 1'b0, 1'b0)) begin
                n_err++;
                $display("FAIL relu_beat%0d: got %h want %h", k, obs(), beat_exp(k, 1'b0, 1'b0));
            end
            tick();
        end
        tick();
    endtask

    task automatic test_overrun;
        fill_random();
        bus.out_ready = 1'b1;
        start_capture();
        for (int k = 0; k < SLEN; k++) begin
            n_cmp++;
            if (obs() !== beat_exp(k, 1'b0, k >= 4)) begin
                n_err++;
                $display("FAIL ovr_beat%0d: got %h want %h", k, obs(), beat_exp(k, 1'b0, k >= 4));
            end
            if (k == 3) begin
                fill_random();
                capture = 1'b1;
                acc_in = pack_stim();
            end
            tick();
            capture = 1'b0;
        end
        n_cmp++;
        if (idle_obs() !== 4'b0011) begin
            n_err++;
            $display("FAIL ovr_done: got %b want 0011", idle_obs());
        end
        tick();
        n_cmp++;
        if (idle_obs() !== 4'b0001) begin
            n_err++;
            $display("FAIL ovr_sticky: got %b want 0001", idle_obs());
        end
    endtask

    task automatic test_async_reset;
        fill_random();
        bus.out_ready = 1'b1;
        start_capture();
        for (int k = 0; k <= 4; k++) begin
            n_cmp++;
            if (obs() !== beat_exp(k, 1'b0, 1'b1)) begin
                n_err++;
                $display("FAIL ar_beat%0d: got %h want %h", k, obs(), beat_exp(k, 1'b0, 1'b1));
            end
            if (k < 4) tick();
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== '0) begin
            n_err++;
            $display("FAIL ar_immediate: got %h want 0", obs());
        end
        #2 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (idle_obs() !== 4'b0000) begin
                n_err++;
                $display("FAIL ar_no_done%0d: got %b want 0000", c, idle_obs());
            end
        end
        fill_random();
        start_capture();
        for (int k = 0; k < SLEN; k++) begin
            n_cmp++;
            if (obs() !== beat_exp(k, 1'b0, 1'b0)) begin
                n_err++;
                $display("FAIL ar_redrain_beat%0d: got %h want %h", k, obs(), beat_exp(k, 1'b0, 1'b0));
            end
            tick();
        end
        n_cmp++;
        if (idle_obs() !== 4'b0010) begin
            n_err++;
            $display("FAIL ar_redrain_done: got %b want 0010", idle_obs());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure(1'b0, 1);
        test_back_to_back();
        test_relu();
        test_backpressure(1'b1, 6);
        test_overrun();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mmu_acc_drain.md
# mmu_acc_drain

Result drain for the MMU chain's accumulator output. It snapshots the full `acc_width*size` accumulator vector on a one-cycle capture strobe. It then streams the snapshot out as `size/mmu_block` beats of `mmu_block` accumulators each, over a valid/ready interface toward the requantization/writeback stage. This decouples the systolic chain from downstream backpressure, so the chain can start its next tile while the previous result drains.

## Interface
- `bit_width`, 8: operand width of the chain; kept for parameter-list compatibility with the chain, unused internally.
- `acc_width`, 24: width of one accumulator lane.
- `size`, 128: total accumulator lanes; must be an integer multiple of `mmu_block`.
- `mmu_block`, 16: lanes per output beat.
- Derived localparam `s_len = size/mmu_block`.
- Derived localparam `idx_w = max(1, $clog2(s_len))`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `capture`  in  1  one-cycle strobe: `acc_in` holds a valid result this cycle.
- `acc_in`  in  acc_width*size  chain accumulator vector; lane block k is `[k*acc_width*mmu_block +: acc_width*mmu_block]`.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  acc_width*mmu_block  current beat (block `out_idx` of the snapshot).
- `out_idx`  out  idx_w  block index of the current beat, 0..s_len-1.
- `out_last`  out  1  high with `out_valid` when `out_idx == s_len-1`.
- `busy`  out  1  snapshot held and not fully drained.
- `done`  out  1  one-cycle pulse after the final beat's handshake.
- `overrun`  out  1  sticky: a capture was dropped.

## Operation
- FSM has two states.
- IDLE:
  - `busy=0`, `out_valid=0`.
  - On `capture`: load the shadow register from `acc_in`, set `idx=0`, go to SEND.
- SEND:
  - `busy=1`, `out_valid=1`.
  - `out_data` = shadow block `idx`, muxed from the registered shadow and `idx`.
  - On handshake (`out_valid & out_ready`) with `idx < s_len-1`: `idx <= idx+1`.
  - On handshake with `idx == s_len-1`:
    - If `capture` is also high: reload the shadow, `idx <= 0`, stay in SEND (back-to-back, no bubble).
    - Otherwise: go to IDLE.
    - In both cases, `done` pulses the next cycle.
- `capture` in SEND without a final handshake that same cycle: the new vector is dropped, the shadow is unchanged, and `overrun <= 1`.
- `overrun` clears only on reset.
- Beat order is always ascending block index, 0 first.
- `out_data`/`out_idx` are held stable while `out_valid & ~out_ready`.
- Accumulator values pass through bit-exact (two's complement), unless the configuration macro is defined.

## Timing
- Reset values: state IDLE, shadow 0, `idx` 0, `out_valid` 0, `out_data` 0, `out_idx` 0, `out_last` 0, `busy` 0, `done` 0, `overrun` 0.
- Reset mid-drain aborts immediately; remaining beats are lost and no `done` pulse is produced.
- Capture at cycle N → `out_valid=1`, `out_idx=0` at cycle N+1.
- With `out_ready` held high: beats at N+1..N+s_len, `done` at N+s_len+1.
- Minimum drain is `s_len` cycles per capture.
- Back-to-back captures exactly every `s_len` cycles sustain 100% output throughput.
- `out_valid` never drops once asserted until the final handshake; `out_ready` may toggle freely.
- `done` is registered; it is high for exactly one cycle per completed snapshot.

## Configuration
- `MMU_ACC_DRAIN_RELU_EN`:
  - Defined: each `acc_width` lane of `out_data` is forced to 0 when its sign bit is 1. This is applied on the output mux path, so the shadow stays raw and no extra latency is added.
  - Undefined: lanes pass through unmodified. There is no ReLU logic.

## Test plan
- Reset, then capture with lane i = i (size=128, mmu_block=16), `out_ready=1`:
  - 8 beats at cycles 1..8 after capture.
  - Beat k lanes = 16k..16k+15.
  - `out_last` only on k=7; `done` at cycle 9.
- Same capture with `out_ready` toggling 1,0,0,1,...:
  - Each beat is held unchanged while stalled.
  - All 8 beats are delivered in order.
  - `done` follows the 8th handshake by 1 cycle.
- Capture asserted in the same cycle as the last handshake, second vector lane i = 1000+i:
  - No idle cycle between vectors.
  - Second vector beat 0 = 1000..1015.
  - `overrun` stays 0.
- Capture at beat 3 of an active drain:
  - `overrun=1` and stays 1.
  - Remaining beats 3..7 still carry the first vector.
- With the macro defined, lanes alternating -5 and +5:
  - Output lanes alternate 0 and 5.
  - Without the macro, output lanes are 0xFFFFFB and 5.
- `rst` asserted asynchronously at beat 4:
  - All outputs go to 0 immediately; no `done`.
  - A subsequent capture drains from `out_idx=0`.
